uart_tx: RTL and testbench

UART transmitter that serialises one byte per request into an 8N1 frame (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) on a single `tx` line. It shares the same oversampled baud-tick generator as the UART receiver: every bit lasts exactly `OVS` `b_tick` pulses. It sits between the system logic (for example, stopwatch/clock report logic) and the board's UART TX pin, and is the transmit-side counterpart of the team's receiver.

---
 rtl/uart_tx.sv | 131 +++++++++++++
 tb/tb_uart_tx.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter. Bit boundaries follow the shared
//               oversampled b_tick grid; each bit lasts OVS ticks.
// Revision    : 1.0 - initial release
// ============================================================================

module uart_tx #(
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b_tick,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SYNC  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  localparam logic [4:0] c_TICK_LAST = 5'(OVS - 1);
  localparam logic [2:0] c_BIT_LAST  = 3'd7;

  logic [2:0] r_state, w_state_next;
  logic [4:0] r_tick_cnt, w_tick_next;
  logic [2:0] r_bit_cnt, w_bit_next;
  logic [7:0] r_shift, w_shift_next;
  logic       r_tx, w_tx_next;
  logic       r_tx_done, w_done_next;
  logic       w_tick_wrap;

  assign w_tick_wrap = b_tick && (r_tick_cnt == c_TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= 5'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_tick_cnt <= w_tick_next;
      r_bit_cnt  <= w_bit_next;
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
      r_tx_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tick_next  = r_tick_cnt;
    w_bit_next   = r_bit_cnt;
    w_shift_next = r_shift;
    case (r_state)
      S_IDLE: begin
        if (tx_start) begin
          w_shift_next = tx_data;
          w_state_next = S_SYNC;
        end
      end
      // Waiting here aligns the start bit to a tick so it is a full OVS ticks.
      S_SYNC: begin
        if (b_tick) begin
          w_tick_next  = 5'd0;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_tick_wrap) begin
          w_tick_next  = 5'd0;
          w_bit_next   = 3'd0;
          w_state_next = S_DATA;
        end else if (b_tick) begin
          w_tick_next = r_tick_cnt + 5'd1;
        end
      end
      S_DATA: begin
        if (w_tick_wrap) begin
          w_tick_next = 5'd0;
          if (r_bit_cnt == c_BIT_LAST) begin
            w_state_next = S_STOP;
          end else begin
            w_shift_next = r_shift >> 1;
            w_bit_next   = r_bit_cnt + 3'd1;
          end
        end else if (b_tick) begin
          w_tick_next = r_tick_cnt + 5'd1;
        end
      end
      S_STOP: begin
        if (w_tick_wrap) begin
          w_tick_next  = 5'd0;
          w_state_next = S_IDLE;
        end else if (b_tick) begin
          w_tick_next = r_tick_cnt + 5'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // The line level is derived from the next state so tx is a clean register.
  always_comb begin
    w_tx_next   = 1'b1;
    w_done_next = (r_state == S_STOP) && w_tick_wrap;
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  assign tx      = r_tx;
  assign tx_busy = (r_state != S_IDLE);
  assign tx_done = r_tx_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Randomised self-checking bench for uart_tx against a frame
//               timeline model and a centre-sampling serial decoder.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_uart_tx;

  localparam int OVS     = 16;
  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_FRAME = 2;

  logic       clk;
  logic       rst;
  logic       b_tick;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx #(.OVS(OVS)) dut (
    .clk      (clk),
    .rst      (rst),
    .b_tick   (b_tick),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick generator: one b_tick every cpt clocks
  int cpt = 3;
  int tick_div = 0;
  initial begin
    b_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_div >= cpt - 1) begin
        tick_div = 0;
        b_tick   = 1'b1;
      end else begin
        tick_div++;
        b_tick = 1'b0;
      end
    end
  end

  // Reference model: frame timeline in ticks since the accepted request
  int         m_phase = P_IDLE;
  int         m_rel = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_done = 1'b0;
  logic       m_in_rst = 1'b1;
  logic       m_tick = 1'b0;
  int         tick_no = 0;
  int         n_acc = 0;
  int         n_abandoned = 0;
  int         n_exp_done = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    m_done   = 1'b0;
    m_in_rst = rst;
    m_tick   = b_tick;
    if (b_tick) tick_no++;
    if (rst) begin
      if (m_phase != P_IDLE && exp_q.size() > 0 &&
          !(m_phase == P_FRAME && m_rel >= 9 * OVS + OVS / 2)) begin
        void'(exp_q.pop_back());
        n_abandoned++;
      end
      m_phase = P_IDLE;
    end else begin
      case (m_phase)
        P_IDLE: if (tx_start) begin
          exp_q.push_back(tx_data);
          m_byte  = tx_data;
          m_phase = P_WAIT;
          n_acc++;
        end
        P_WAIT: if (b_tick) begin
          m_phase = P_FRAME;
          m_rel   = 0;
        end
        default: if (b_tick) begin
          m_rel++;
          if (m_rel == 10 * OVS) begin
            m_phase = P_IDLE;
            m_done  = 1'b1;
            n_exp_done++;
          end
        end
      endcase
    end
  end

  function automatic logic model_tx();
    int idx;
    if (m_phase != P_FRAME) return 1'b1;
    idx = m_rel / OVS;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return m_byte[idx-1];
  endfunction

  // Output comparison whenever any observed or expected output changes
  logic       chk_en = 1'b0;
  logic       idle_win = 1'b0;
  int         idle_bad = 0;
  int         n_dut_done = 0;
  logic [5:0] prev_obs = 6'h3f;
  logic       prev_tx = 1'b1;

  always @(negedge clk) begin
    logic e_tx, e_busy;
    logic [5:0] obs;
    if (chk_en) begin
      e_tx   = model_tx();
      e_busy = (m_phase != P_IDLE);
      obs    = {tx, tx_busy, tx_done, e_tx, e_busy, m_done};
      if (obs !== prev_obs) begin
        check("tx", 32'(tx), 32'(e_tx));
        check("tx_busy", 32'(tx_busy), 32'(e_busy));
        check("tx_done", 32'(tx_done), 32'(m_done));
      end
      if (tx !== prev_tx && !m_in_rst)
        check("tx_on_tick", 32'(m_tick), 32'd1);
      if (tx_done === 1'b1) n_dut_done++;
      if (idle_win && (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0)) idle_bad++;
      prev_obs = obs;
      prev_tx  = tx;
    end
  end

  // Serial decoder: samples the line at the centre of each bit
  logic       d_active = 1'b0;
  logic       d_prev = 1'b1;
  int         d_start = 0;
  int         d_last = -1;
  logic [7:0] d_byte = 8'h00;
  int         rx_count = 0;
  int         falls[$];

  always @(negedge clk) begin
    int rel, k;
    if (!chk_en || m_in_rst) begin
      d_active = 1'b0;
      d_prev   = 1'b1;
    end else begin
      if (!d_active && d_prev === 1'b1 && tx === 1'b0) begin
        d_active = 1'b1;
        d_start  = tick_no;
        d_last   = -1;
        falls.push_back(tick_no);
      end
      if (d_active) begin
        rel = tick_no - d_start;
        if (rel != d_last && rel % OVS == OVS / 2) begin
          k = rel / OVS;
          if (k == 0) begin
            check("rx_start_bit", 32'(tx), 32'd0);
          end else if (k <= 8) begin
            d_byte[k-1] = tx;
          end else begin
            check("rx_stop_bit", 32'(tx), 32'd1);
            if (exp_q.size() > 0) check("rx_byte", 32'(d_byte), 32'(exp_q.pop_front()));
            else check("rx_unexpected", 32'd1, 32'd0);
            rx_count++;
            d_active = 1'b0;
          end
        end
        d_last = rel;
      end
      d_prev = tx;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_phase != P_IDLE && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) check("idle_timeout", 32'd1, 32'd0);
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_rel(input int target);
    int n = 0;
    while (!(m_phase == P_FRAME && m_rel >= target) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) check("rel_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, f0;
    logic [7:0] lb[3];
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    idle_win = 1'b1;
    repeat (1000) @(negedge clk);
    idle_win = 1'b0;
    check("idle_quiet", 32'(idle_bad), 32'd0);

    foreach (lb[i]) lb[i] = 8'h00;
    lb[0] = 8'h55; lb[1] = 8'h00; lb[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      d0 = n_dut_done;
      send(lb[i]);
      wait_idle();
      check("single_done_pulse", 32'(n_dut_done - d0), 32'd1);
    end

    // Request during a frame is ignored
    d0 = n_dut_done; r0 = rx_count;
    send(8'h41);
    wait_rel(50);
    send(8'hAA);
    wait_idle();
    repeat (700) @(negedge clk);
    check("ignore_busy_rx", 32'(rx_count - r0), 32'd1);
    check("ignore_busy_done", 32'(n_dut_done - d0), 32'd1);

    // Back-to-back: second request placed in the tx_done cycle
    d0 = n_dut_done; r0 = rx_count; f0 = falls.size();
    send(8'h41);
    begin
      int n = 0;
      while (!m_done && n < 4000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 4000) check("done_timeout", 32'd1, 32'd0);
    end
    tx_start = 1'b1;
    tx_data  = 8'h42;
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle();
    check("b2b_rx", 32'(rx_count - r0), 32'd2);
    check("b2b_done", 32'(n_dut_done - d0), 32'd2);
    if (falls.size() >= f0 + 2)
      check("b2b_gap_ticks", 32'(falls[f0+1] - falls[f0]), 32'(10 * OVS + 1));
    else
      check("b2b_frames", 32'(falls.size() - f0), 32'd2);

    // Reset in the middle of data bit 3
    send(8'hA5);
    wait_rel(4 * OVS + 6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    check("midrst_done", 32'(tx_done), 32'd0);
    repeat (20) @(negedge clk);
    send(8'h3C);
    wait_idle();

    lb[0] = 8'hA5; lb[1] = 8'h5A; lb[2] = 8'h0D;
    for (int i = 0; i < 3; i++) begin
      send(lb[i]);
      wait_idle();
    end

    for (int it = 0; it < 12; it++) begin
      cpt = int'($urandom_range(1, 4));
      repeat ($urandom_range(0, 7)) @(negedge clk);
      send(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 300)) @(negedge clk);
        send(8'($urandom));
      end
      wait_idle();
      wait_idle();
    end

    repeat (50) @(negedge clk);
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(n_dut_done), 32'(n_exp_done));
    check("rx_count", 32'(rx_count), 32'(n_acc - n_abandoned));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
